// File: rtl/vector_logger_pkg.sv
// Shared types and MISR helpers for the exhaustive vector logger.
package vector_logger_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'h0000;

   // One serial CRC-CCITT step folding a single response bit into the signature.
   function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic bit_in);
      logic fb;
      fb = sig[15] ^ bit_in;
      return {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/record_fifo.sv
// Synchronous record FIFO with registered full/empty flags and a zeroed store on reset.
module record_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [AW:0]      count_next;
   logic             full_reg;
   logic             empty_reg;
   logic             do_push;
   logic             do_pop;
   logic [WIDTH-1:0] entry_q [DEPTH];

   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign do_push = push && !full_reg;
   assign do_pop  = pop && !empty_reg;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + 1'b1;
      end else if (!do_push && do_pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
         logic [WIDTH-1:0] entry_reg;
         always_ff @(posedge CK) begin
            if (!reset) begin
               entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
               entry_reg <= push_data;
            end
         end
         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge CK) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         full_reg  <= (count_next == (AW+1)'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

   assign pop_data = entry_q[rd_ptr_reg];
   assign full     = full_reg;
   assign empty    = empty_reg;

endmodule

// File: rtl/exhaustive_vector_logger.sv
// Sweeps every input vector of a combinational DUT, logging {vector, response}
// records through a FIFO while accumulating a MISR signature and a ones count.
module exhaustive_vector_logger
   import vector_logger_pkg::*;
#(
   parameter int N_IN       = 7,
   parameter int SETTLE     = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            CK,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] vec_out,
   input  logic            dut_resp,
   output logic            busy,
   output logic            done,
   output logic            rec_valid,
   input  logic            rec_ready,
   output logic [N_IN:0]   rec_data,
   output logic [15:0]     signature,
   output logic [N_IN:0]   ones_count
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE - 1);

   state_t          state_reg;
   logic [N_IN-1:0] vec_reg;
   logic [SCW-1:0]  settle_reg;
   logic [15:0]     sig_reg;
   logic [N_IN:0]   ones_reg;
   logic            busy_reg;
   logic            done_reg;

   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            last_vec;

   assign push     = (state_reg == ST_SAMPLE) && !fifo_full;
   assign pop      = rec_valid && rec_ready;
   assign last_vec = &vec_reg;

   record_fifo #(
      .WIDTH (N_IN + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_record_fifo (
      .CK        (CK),
      .reset     (reset),
      .push      (push),
      .push_data ({vec_reg, dut_resp}),
      .pop       (pop),
      .pop_data  (rec_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge CK) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         vec_reg    <= '0;
         settle_reg <= '0;
         sig_reg    <= MISR_SEED;
         ones_reg   <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg  <= ST_SETTLE;
                  vec_reg    <= '0;
                  settle_reg <= SETTLE_LOAD;
                  sig_reg    <= MISR_SEED;
                  ones_reg   <= '0;
                  busy_reg   <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (settle_reg == '0) begin
                  state_reg <= ST_SAMPLE;
               end else begin
                  settle_reg <= settle_reg - 1'b1;
               end
            end
            ST_SAMPLE: begin
               // While the FIFO is full the vector is held and the response resampled.
               if (push) begin
                  sig_reg  <= misr_step(sig_reg, dut_resp);
                  ones_reg <= ones_reg + {{N_IN{1'b0}}, dut_resp};
                  if (last_vec) begin
                     state_reg <= ST_DRAIN;
                  end else begin
                     vec_reg    <= vec_reg + 1'b1;
                     settle_reg <= SETTLE_LOAD;
                     state_reg  <= ST_SETTLE;
                  end
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            ST_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign vec_out    = vec_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign rec_valid  = !fifo_empty;
   assign signature  = sig_reg;
   assign ones_count = ones_reg;

endmodule

// File: doc/exhaustive_vector_logger.md
# exhaustive_vector_logger

Hardware stimulus/response logger for the trojan-detection benchmark flow. It drives every input combination of an `N_IN`-input combinational DUT in ascending binary order and waits a settle interval. It then samples the DUT's single-bit response and streams `{vector, response}` records out over a valid/ready port, the same record content as the simulation output files. A running 16-bit MISR signature and a ones-count are also kept, so a full sweep can be compared against a golden value without reading every record.

## Interface
Parameters:
- `N_IN`, 7, DUT input width; number of vectors = 2^N_IN.
- `SETTLE`, 1, cycles a vector is held before sampling (≥1).
- `FIFO_DEPTH`, 8, record buffer depth (power of two, ≥2).

Ports:
- `CK`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `vec_out`  out  N_IN  vector applied to DUT; bit N_IN-1 is MSB.
- `dut_resp`  in  1  DUT response.
- `busy`  out  1  high from the cycle after an accepted start until DONE.
- `done`  out  1  one-cycle pulse when the sweep is complete and the buffer is empty.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts the record when `rec_valid && rec_ready`.
- `rec_data`  out  N_IN+1  `{vector, response}`; response is the LSB.
- `signature`  out  16  MISR value.
- `ones_count`  out  N_IN+1  number of samples with `dut_resp`=1.

## Operation
- FSM states:
  - IDLE → SETTLE on `start`.
  - SETTLE → SAMPLE when the settle counter expires.
  - SAMPLE → SETTLE on push when the vector is not the last.
  - SAMPLE → DRAIN on push of the last vector.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → IDLE unconditionally.
- On start: `vec_out`←0, `signature`←0x0000, `ones_count`←0, settle counter←SETTLE-1.
- SETTLE: the counter decrements each cycle; at 0, go to SAMPLE.
- SAMPLE: if the FIFO is not full (registered full flag), push `{vec_out, dut_resp}` and update the MISR and `ones_count` in the same cycle.
  - On a push, `vec_out` increments unless it equals the last vector (all ones).
  - If the FIFO is full, stay in SAMPLE with `vec_out` held. `dut_resp` is sampled in the cycle the push is accepted.
- MISR, serial CRC-CCITT update per sample: fb = `signature[15]` ^ `dut_resp`; `signature` ← {`signature[14:0]`,0} ^ (fb ? 0x1021 : 0).
- `ones_count` never wraps; its width holds 2^N_IN.
- DRAIN: no pushes; wait for the FIFO to empty.
- DONE: `done`=1 and `busy`=0; the next state is IDLE.
- `signature`, `ones_count` and `vec_out` hold their final values until the next start.
- `start` outside IDLE is ignored. `start` in the DONE cycle is ignored.
- FIFO: pop when `rec_valid && rec_ready`. Push and pop in the same cycle are allowed when not full. A full FIFO blocks a push even if a pop happens in the same cycle.
- `rec_data` is stable while `rec_valid` is high and not yet accepted.
- Reset (any state, including mid-sweep):
  - State → IDLE, FIFO flushed.
  - All outputs 0: `vec_out`, `busy`, `done`, `rec_valid`, `rec_data`, `signature`, `ones_count`.

## Timing
- Start accepted at edge k: `vec_out`=0 and `busy`=1 from cycle k+1.
- With no backpressure, each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus one in SAMPLE.
- A full sweep with no backpressure takes 2^N_IN·(SETTLE+1) cycles.
- A record is visible on `rec_valid` the cycle after its push (FIFO latency 1).
- `done` asserts the cycle after DRAIN sees the FIFO empty. Minimum gap from the last push to `done` is 2 cycles.
- Each backpressure stall adds exactly one cycle per blocked SAMPLE cycle. No records are lost or duplicated.

## Structure
- Package `vector_logger_pkg`:
  - state enum (IDLE, SETTLE, SAMPLE, DRAIN, DONE);
  - `MISR_POLY`=16'h1021;
  - `MISR_SEED`=16'h0000.
- Sub-module `record_fifo`: synchronous FIFO, parameterised width and depth. Registered full/empty; the same active-low synchronous reset.
- The top module contains the FSM, vector counter, settle counter, MISR and ones counter.

## Test plan
- **Basic sweep.** N_IN=2, SETTLE=1, `rec_ready`=1, `dut_resp`=0 → 4 records `000,010,100,110`; `signature`=0x0000; `ones_count`=0; `done` at cycle 8 plus drain latency.
- **Single hit.** N_IN=2, `dut_resp`=1 only when `vec_out`=3 → last record `111`; `signature`=0x1021; `ones_count`=1.
- **Full-width match.** N_IN=7, SETTLE=2, `dut_resp`=^`vec_out` → 128 records in order; `ones_count`=64; `signature` equals the bench MISR model; total cycles = 384 + drain.
- **Backpressure.** FIFO_DEPTH=2, `rec_ready`=0 for 20 cycles then 1 → `vec_out` holds at 2 while stalled; no loss or duplication; record order is unchanged.
- **Reset mid-sweep.** Assert `reset`=0 at vector 5 → the next cycle has every output at 0 and state IDLE; a new start yields a clean full sweep.
- **Ignored start.** Pulse `start` during SETTLE and during DONE → no restart; the sweep and its results are unaffected.
